// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg -- shared control-op encoding and instruction size for the
// program-counter sequencer.
package pc_seq_pkg;

    // Control op codes carried on the 3-bit op input; codes 5-7 act as SEQ.
    typedef enum logic [2:0] {
        SEQ    = 3'd0,
        BRANCH = 3'd1,
        JUMP   = 3'd2,
        CALL   = 3'd3,
        RET    = 3'd4
    } op_t;

    // Fixed instruction size; sequential flow and return addresses step by this.
    localparam int INSN_BYTES = 4;

endpackage : pc_seq_pkg

// File: rtl/pc_ras.sv
// pc_ras -- circular-buffer return-address stack. A push onto a full stack
// overwrites the oldest entry, so the newest RAS_DEPTH return addresses
// always survive. Push and pop are never requested together.
module pc_ras #(
    parameter int XLEN      = 32,
    parameter int RAS_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic                         pop,
    input  logic [XLEN-1:0]              push_data,
    output logic [XLEN-1:0]              top,
    output logic [$clog2(RAS_DEPTH):0]   count,
    output logic                         full,
    output logic                         empty
);
    localparam int AW = $clog2(RAS_DEPTH);
    localparam int CW = AW + 1;

    logic [XLEN-1:0] mem [RAS_DEPTH];
    logic [AW-1:0]   wr_ptr;   // next free slot; top lives at wr_ptr - 1

    assign full  = (count == CW'(RAS_DEPTH));
    assign empty = (count == '0);
    assign top   = mem[wr_ptr - AW'(1)];

    // Pointer and occupancy tracking; the pointer wraps because depth is a power of two.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            count  <= '0;
        end else if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
            if (!full) count <= count + CW'(1);
        end else if (pop) begin
            wr_ptr <= wr_ptr - AW'(1);
            count  <= count - CW'(1);
        end
    end

    // Entry storage; contents are don't-care until count says they are valid.
    // NOTE: the storage array is deliberately not reset -- count gates validity, and leaving it out keeps it plain RAM.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

endmodule : pc_ras

// File: rtl/pc_sequencer.sv
// pc_sequencer -- program-counter sequencer with trap redirect, stall,
// branch/jump/call/return and a return-address stack.
// Optional feature: define PC_SEQ_ALIGN_CHECK_EN to trap on misaligned
// control-flow targets (adds the misalign output); otherwise target bits
// [1:0] are forced to zero.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_VEC = XLEN'(32'h0000_0000),
    parameter logic [XLEN-1:0] TRAP_VEC  = XLEN'(32'h0000_0100),
    parameter int              RAS_DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       stall,
    input  logic [2:0]                 op,
    input  logic [XLEN-1:0]            imm,
    input  logic                       trap_req,
    output logic [XLEN-1:0]            pc,
    output logic [XLEN-1:0]            pc_next,
    output logic [$clog2(RAS_DEPTH):0] ras_count,
    output logic                       ras_ovf,
`ifdef PC_SEQ_ALIGN_CHECK_EN
    output logic                       misalign,
`endif
    output logic                       ras_unf
);
    logic [XLEN-1:0] seq_pc;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] ras_top;
    logic            ras_full;
    logic            ras_empty;
    logic            is_ctrl;
    logic            push_req, pop_req, unf_req;
    logic            advance;
    logic            ras_push, ras_pop;
    logic            ovf_set, unf_set;
`ifdef PC_SEQ_ALIGN_CHECK_EN
    logic            misalign_set;
`endif

    assign seq_pc  = pc + XLEN'(INSN_BYTES);
    assign advance = !trap_req && !stall;

    // Decode the op into a raw target and stack requests.
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        target   = seq_pc;
        is_ctrl  = 1'b0;
        push_req = 1'b0;
        pop_req  = 1'b0;
        unf_req  = 1'b0;
        case (op)
            BRANCH: begin
                target  = pc + imm;
                is_ctrl = 1'b1;
            end
            JUMP: begin
                target  = imm;
                is_ctrl = 1'b1;
            end
            CALL: begin
                target   = imm;
                is_ctrl  = 1'b1;
                push_req = 1'b1;
            end
            RET: begin
                if (!ras_empty) begin
                    target  = ras_top;
                    is_ctrl = 1'b1;
                    pop_req = 1'b1;
                end else begin
                    unf_req = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Final next-PC selection: trap beats stall beats the decoded op.
    always_comb begin
        pc_next = target;
`ifdef PC_SEQ_ALIGN_CHECK_EN
        misalign_set = advance && is_ctrl && (target[1:0] != 2'b00);
        if (misalign_set) pc_next = TRAP_VEC;
`else
        if (is_ctrl) pc_next = {target[XLEN-1:2], 2'b00};
`endif
        if (stall)    pc_next = pc;
        if (trap_req) pc_next = TRAP_VEC;
    end

    // Stack is only touched by an op that actually advances this cycle.
    assign ras_push = advance && push_req;
    assign ras_pop  = advance && pop_req;
    assign ovf_set  = ras_push && ras_full;
    assign unf_set  = advance && unf_req;

    pc_ras #(
        .XLEN      (XLEN),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (ras_push),
        .pop       (ras_pop),
        .push_data (seq_pc),
        .top       (ras_top),
        .count     (ras_count),
        .full      (ras_full),
        .empty     (ras_empty)
    );

    // PC register and one-cycle event flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc       <= RESET_VEC;
            ras_ovf  <= 1'b0;
            ras_unf  <= 1'b0;
`ifdef PC_SEQ_ALIGN_CHECK_EN
            misalign <= 1'b0;
`endif
        end else begin
            pc       <= pc_next;
            ras_ovf  <= ovf_set;
            ras_unf  <= unf_set;
`ifdef PC_SEQ_ALIGN_CHECK_EN
            misalign <= misalign_set;
`endif
        end
    end

endmodule : pc_sequencer

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer -- directed self-checking bench for pc_sequencer with
// default parameters. Inputs change and outputs are sampled 1 ns after
// the rising edge. Honors PC_SEQ_ALIGN_CHECK_EN if defined.
module tb_pc_sequencer;
    import pc_seq_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic [2:0]  op;
    logic [31:0] imm;
    logic        trap_req;
    logic [31:0] pc;
    logic [31:0] pc_next;
    logic [2:0]  ras_count;
    logic        ras_ovf;
    logic        ras_unf;
`ifdef PC_SEQ_ALIGN_CHECK_EN
    logic        misalign;
`endif

    int errors = 0;
    int checks = 0;

    pc_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .stall     (stall),
        .op        (op),
        .imm       (imm),
        .trap_req  (trap_req),
        .pc        (pc),
        .pc_next   (pc_next),
        .ras_count (ras_count),
        .ras_ovf   (ras_ovf),
`ifdef PC_SEQ_ALIGN_CHECK_EN
        .misalign  (misalign),
`endif
        .ras_unf   (ras_unf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge, then settle.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one op for one cycle.
    task automatic issue(input logic [2:0] o, input logic [31:0] i);
        op  = o;
        imm = i;
        step();
    endtask

    // Full reset away from clock edges, leaving inputs idle.
    task automatic do_reset();
        stall = 1'b0; trap_req = 1'b0; op = SEQ; imm = '0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        checks++; if (pc !== 32'h0) begin errors++; $display("FAIL reset_pc got=%h exp=%h", pc, 32'h0); end
        checks++; if (ras_count !== 3'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", ras_count); end
        checks++; if (ras_ovf !== 1'b0 || ras_unf !== 1'b0) begin errors++; $display("FAIL reset_flags got=%b%b exp=00", ras_ovf, ras_unf); end
    endtask

    task automatic test_seq();
        logic [31:0] exp_pc [3] = '{32'h4, 32'h8, 32'hC};
        do_reset();
        op = SEQ; #1;
        checks++; if (pc_next !== 32'h4) begin errors++; $display("FAIL seq_pc_next got=%h exp=%h", pc_next, 32'h4); end
        for (int k = 0; k < 3; k++) begin
            issue(SEQ, '0);
            checks++; if (pc !== exp_pc[k]) begin errors++; $display("FAIL seq_pc[%0d] got=%h exp=%h", k, pc, exp_pc[k]); end
        end
        // undefined op code behaves as SEQ
        issue(3'd6, 32'h1234);
        checks++; if (pc !== 32'h10) begin errors++; $display("FAIL seq_op6 got=%h exp=%h", pc, 32'h10); end
    endtask

    task automatic test_branch_wrap();
        do_reset();
        issue(JUMP, 32'h100);
        issue(BRANCH, 32'hFFFF_FFF8);
        checks++; if (pc !== 32'hF8) begin errors++; $display("FAIL branch_neg got=%h exp=%h", pc, 32'hF8); end
        issue(BRANCH, 32'h20);
        checks++; if (pc !== 32'h118) begin errors++; $display("FAIL branch_pos got=%h exp=%h", pc, 32'h118); end
        issue(JUMP, 32'hFFFF_FFFC);
        issue(SEQ, '0);
        checks++; if (pc !== 32'h0) begin errors++; $display("FAIL seq_wrap got=%h exp=%h", pc, 32'h0); end
    endtask

    task automatic test_ras();
        logic [31:0] ret_pc [4] = '{32'h54, 32'h44, 32'h34, 32'h24};
        logic [2:0]  exp_cnt [5] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd4};
        do_reset();
        issue(JUMP, 32'h10);
        for (int k = 0; k < 5; k++) begin
            issue(CALL, 32'h20 + 32'(k) * 32'h10);
            checks++; if (pc !== 32'h20 + 32'(k) * 32'h10) begin errors++; $display("FAIL call_pc[%0d] got=%h", k, pc); end
            checks++; if (ras_count !== exp_cnt[k]) begin errors++; $display("FAIL call_count[%0d] got=%0d exp=%0d", k, ras_count, exp_cnt[k]); end
            checks++; if (ras_ovf !== (k == 4)) begin errors++; $display("FAIL call_ovf[%0d] got=%b exp=%b", k, ras_ovf, k == 4); end
        end
        for (int k = 0; k < 4; k++) begin
            issue(RET, '0);
            checks++; if (pc !== ret_pc[k]) begin errors++; $display("FAIL ret_pc[%0d] got=%h exp=%h", k, pc, ret_pc[k]); end
            checks++; if (ras_count !== 3'(3 - k)) begin errors++; $display("FAIL ret_count[%0d] got=%0d exp=%0d", k, ras_count, 3 - k); end
            checks++; if (ras_ovf !== 1'b0 || ras_unf !== 1'b0) begin errors++; $display("FAIL ret_flags[%0d] got=%b%b exp=00", k, ras_ovf, ras_unf); end
        end
        issue(RET, '0);
        checks++; if (pc !== 32'h28) begin errors++; $display("FAIL unf_pc got=%h exp=%h", pc, 32'h28); end
        checks++; if (ras_unf !== 1'b1 || ras_count !== 3'd0) begin errors++; $display("FAIL unf_flag got=%b/%0d exp=1/0", ras_unf, ras_count); end
        issue(SEQ, '0);
        checks++; if (ras_unf !== 1'b0 || pc !== 32'h2C) begin errors++; $display("FAIL unf_pulse got=%b/%h exp=0/%h", ras_unf, pc, 32'h2C); end
    endtask

    task automatic test_stall_trap();
        do_reset();
        issue(JUMP, 32'h200);
        issue(CALL, 32'h300);
        op = CALL; imm = 32'h400; stall = 1'b1; #1;
        checks++; if (pc_next !== 32'h300) begin errors++; $display("FAIL stall_pc_next got=%h exp=%h", pc_next, 32'h300); end
        for (int k = 0; k < 3; k++) begin
            step();
            checks++; if (pc !== 32'h300 || ras_count !== 3'd1) begin errors++; $display("FAIL stall[%0d] got=%h/%0d exp=300/1", k, pc, ras_count); end
        end
        trap_req = 1'b1; #1;
        checks++; if (pc_next !== 32'h100) begin errors++; $display("FAIL trap_pc_next got=%h exp=%h", pc_next, 32'h100); end
        step();
        checks++; if (pc !== 32'h100 || ras_count !== 3'd1) begin errors++; $display("FAIL trap got=%h/%0d exp=100/1", pc, ras_count); end
        trap_req = 1'b0; stall = 1'b0;
        issue(RET, '0);
        checks++; if (pc !== 32'h204) begin errors++; $display("FAIL trap_ras_kept got=%h exp=%h", pc, 32'h204); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        issue(CALL, 32'h40);
        issue(CALL, 32'h80);
        checks++; if (ras_count !== 3'd2) begin errors++; $display("FAIL mid_pre_count got=%0d exp=2", ras_count); end
        op = CALL; imm = 32'hC0; stall = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        checks++; if (pc !== 32'h0 || ras_count !== 3'd0) begin errors++; $display("FAIL mid_async got=%h/%0d exp=0/0", pc, ras_count); end
        step();
        checks++; if (pc !== 32'h0) begin errors++; $display("FAIL mid_held got=%h exp=0", pc); end
        @(negedge clk);
        rst_n = 1'b1; stall = 1'b0; op = SEQ; imm = '0;
        step();
        checks++; if (pc !== 32'h4 || ras_count !== 3'd0) begin errors++; $display("FAIL mid_post got=%h/%0d exp=4/0", pc, ras_count); end
    endtask

    task automatic test_align();
        do_reset();
        issue(JUMP, 32'h102);
        checks++; if (pc !== 32'h100) begin errors++; $display("FAIL align_jump got=%h exp=%h", pc, 32'h100); end
`ifdef PC_SEQ_ALIGN_CHECK_EN
        checks++; if (misalign !== 1'b1) begin errors++; $display("FAIL align_pulse got=%b exp=1", misalign); end
        issue(SEQ, '0);
        checks++; if (misalign !== 1'b0 || pc !== 32'h104) begin errors++; $display("FAIL align_clear got=%b/%h exp=0/104", misalign, pc); end
        issue(BRANCH, 32'h6);
        checks++; if (pc !== 32'h100 || misalign !== 1'b1) begin errors++; $display("FAIL align_branch got=%h/%b exp=100/1", pc, misalign); end
`else
        issue(SEQ, '0);
        checks++; if (pc !== 32'h104) begin errors++; $display("FAIL align_seq got=%h exp=%h", pc, 32'h104); end
        issue(BRANCH, 32'h6);
        checks++; if (pc !== 32'h108) begin errors++; $display("FAIL align_branch got=%h exp=%h", pc, 32'h108); end
`endif
    endtask

    initial begin
        rst_n = 1'b0; stall = 1'b0; trap_req = 1'b0; op = SEQ; imm = '0;
        #12;
        test_reset();
        test_seq();
        test_branch_wrap();
        test_ras();
        test_stall_trap();
        test_reset_mid();
        test_align();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_pc_sequencer

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter XLEN, default 32, PC and address width (>= 8).
REQ-002 Parameter RESET_VEC, default 32'h0000_0000, PC value loaded by reset.
REQ-003 Parameter TRAP_VEC, default 32'h0000_0100, PC value loaded on trap.
REQ-004 Parameter RAS_DEPTH, default 4, return-address-stack entries (power of 2, >= 2).
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 stall  input  1  hold PC and RAS this cycle.
REQ-008 op  input  3  control op: SEQ=0, BRANCH=1, JUMP=2, CALL=3, RET=4; codes 5-7 treated as SEQ.
REQ-009 imm  input  XLEN  signed branch offset (BRANCH) or absolute target (JUMP, CALL).
REQ-010 trap_req  input  1  redirect to TRAP_VEC.
REQ-011 pc  output  XLEN  current registered PC.
REQ-012 pc_next  output  XLEN  combinational value pc takes at next edge.
REQ-013 ras_count  output  $clog2(RAS_DEPTH)+1  valid RAS entries.
REQ-014 ras_ovf  output  1  one-cycle pulse: CALL overwrote oldest entry.
REQ-015 ras_unf  output  1  one-cycle pulse: RET with empty RAS.

Function
REQ-016 Priority per cycle: trap_req > stall > op.
REQ-017 trap_req: pc_next = TRAP_VEC; RAS unchanged; overrides stall.
REQ-018 stall (no trap): pc_next = pc; RAS, ras_count unchanged; ras_ovf/ras_unf low.
REQ-019 SEQ: pc_next = pc + 4, modulo 2^XLEN (FFFF_FFFC -> 0000_0000).
REQ-020 BRANCH: pc_next = pc + imm, two's-complement, modulo 2^XLEN.
REQ-021 JUMP: pc_next = imm.
REQ-022 CALL: pc_next = imm; push pc + 4 (modulo 2^XLEN); ras_count increments, saturating at RAS_DEPTH.
REQ-023 CALL with RAS full: push overwrites oldest entry (circular); ras_count stays RAS_DEPTH; ras_ovf pulses next cycle.
REQ-024 RET with RAS non-empty: pc_next = top entry; pop; ras_count decrements.
REQ-025 RET with RAS empty: pc_next = pc + 4; ras_unf pulses next cycle; ras_count stays 0.
REQ-026 pc updates one edge after inputs (latency 1); pc_next has zero latency.
REQ-027 ras_ovf and ras_unf are registered, high exactly one cycle per event.

Reset
REQ-028 rst_n low asynchronously sets pc = RESET_VEC, ras_count = 0, ras_ovf = 0, ras_unf = 0; RAS contents don't-care.
REQ-029 Reset mid-operation (incl. during stall/trap) discards pending op; first post-reset edge with op=SEQ gives RESET_VEC + 4.
REQ-030 Reset deassertion takes effect at next rising edge; no state change while rst_n low.

Configuration
REQ-031 Macro PC_SEQ_ALIGN_CHECK_EN defined: BRANCH/JUMP/CALL/RET target with bits [1:0] != 0 redirects pc_next to TRAP_VEC; extra output misalign (1-cycle registered pulse); CALL still pushes, RET still pops.
REQ-032 Macro undefined: target bits [1:0] forced to 0; no misalign port.

Structure
REQ-033 Package pc_seq_pkg holds the op_t enum (SEQ, BRANCH, JUMP, CALL, RET) and the constant INSN_BYTES = 4.
REQ-034 Sub-module pc_ras: circular-buffer return-address stack (push, pop, top, count, full, empty), parametrised by XLEN and RAS_DEPTH.
REQ-035 Next-PC mux is combinational in pc_sequencer; pc and pulse flags are the only registers outside pc_ras.

Verification
REQ-036 Reset then 3x SEQ -> pc = 0, 4, 8, C.
REQ-037 pc = 0x100, BRANCH imm = -8 -> pc = 0xF8; pc = 0xFFFF_FFFC, SEQ -> pc = 0.
REQ-038 RAS_DEPTH = 4, 5 CALLs from pc 0x10, 0x20, 0x30, 0x40, 0x50 (imm = pc + 0x10) -> ras_ovf pulses on the 5th CALL; 4 RETs return 0x54, 0x44, 0x34, 0x24; 5th RET -> ras_unf, pc = previous + 4.
REQ-039 stall held 3 cycles during CALL -> pc and ras_count frozen; trap_req during stall -> pc = 0x100.
REQ-040 rst_n pulsed low mid-CALL sequence with ras_count = 2 -> pc = RESET_VEC and ras_count = 0 immediately, before the clock edge.
REQ-041 With PC_SEQ_ALIGN_CHECK_EN: JUMP imm = 0x102 -> pc = 0x100, misalign pulses; without the macro -> pc = 0x100, no trap.
